ppu: RTL and testbench

//  Post-processing unit at the systolic-MAC output. Takes one 16-lane vector of 24-bit partial sums,

---
 rtl/ppu_pkg.sv | 46 ++++
 rtl/ppu_recip_div.sv | 73 +++++++
 rtl/ppu.sv | 155 +++++++++++++++
 tb/tb_ppu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
// =============================================================================
// ppu_pkg : shared widths, E4M3 field constants and FSM states for ppu
// Revision : 1.0
// =============================================================================
package ppu_pkg;

  localparam int LANES       = 16;
  localparam int PSUM_W      = 24;
  localparam int SCALED_W    = 40;
  localparam int FRAC_W      = 8;
  localparam int INT_W       = SCALED_W - FRAC_W;
  localparam int MAX_W       = 18;
  localparam int QMAX        = 127;
  localparam int Q_W         = 8;
  localparam int PROD_W      = 48;
  localparam int QP_W        = INT_W + MAX_W;

  localparam int E4M3_BIAS   = 7;
  localparam int E4M3_EXP_W  = 4;
  localparam int E4M3_MAN_W  = 3;
  // mantissa carries 3 fraction bits, exponent bias 7, result lands in Q.8
  localparam int SHIFT_ADJ   = E4M3_BIAS + E4M3_MAN_W - FRAC_W;

  localparam int RECIP_FRAC  = 17;
  localparam int RECIP_ITERS = MAX_W;
  localparam int ROUND_HALF  = 1 << (RECIP_FRAC - 1);
  localparam logic [31:0] RECIP_NUM = 32'(QMAX) << RECIP_FRAC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCALE = 3'd1,
    S_MAX   = 3'd2,
    S_RECIP = 3'd3,
    S_QUANT = 3'd4
  } state_t;

  function automatic logic [7:0] lead_one(input logic [MAX_W-1:0] v);
    lead_one = 8'd0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) lead_one = 8'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_recip_div.sv
`default_nettype none
// =============================================================================
// ppu_recip_div : 18-cycle restoring divider producing floor(QMAX*2^17 / d)
// Revision : 1.0
// =============================================================================
module ppu_recip_div
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [MAX_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [MAX_W-1:0] o_quot
);

  localparam logic [MAX_W-1:0] NUM_HI = MAX_W'(RECIP_NUM >> MAX_W);
  localparam logic [MAX_W-1:0] NUM_LO = RECIP_NUM[MAX_W-1:0];
  localparam int               CNT_W  = $clog2(RECIP_ITERS);

  logic [MAX_W-1:0] r_rem;
  logic [MAX_W-1:0] r_num;
  logic [MAX_W-1:0] r_div;
  logic [MAX_W-2:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_sat;

  logic [MAX_W:0]   w_trial;
  logic [MAX_W:0]   w_diff;
  logic             w_ge;

  // remainder stays below the divisor, so the borrow bit alone decides the step
  assign w_trial = {r_rem, r_num[MAX_W-1]};
  assign w_diff  = w_trial - {1'b0, r_div};
  assign w_ge    = ~w_diff[MAX_W];

  assign o_busy  = r_busy;
  assign o_done  = r_busy && (r_cnt == CNT_W'(RECIP_ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_num  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_sat  <= 1'b0;
      o_quot <= '0;
    end else if (i_start) begin
      r_rem  <= NUM_HI;
      r_num  <= NUM_LO;
      r_div  <= i_divisor;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_sat  <= (i_divisor <= NUM_HI);
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff[MAX_W-1:0] : w_trial[MAX_W-1:0];
      r_num <= {r_num[MAX_W-2:0], 1'b0};
      r_q   <= {r_q[MAX_W-3:0], w_ge};
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done) begin
        r_busy <= 1'b0;
        o_quot <= r_sat ? {MAX_W{1'b1}} : {r_q, w_ge};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppu.sv
`default_nettype none
// =============================================================================
// ppu : FP8 gamma scale + bias, vector max, reciprocal and INT8 re-quantization
// Revision : 1.0
// =============================================================================
module ppu
  import ppu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*PSUM_W-1:0]   partial_sum,
  input  logic [7:0]                scale,
  input  logic [7:0]                bias,
  input  logic                      valid,
  output logic [LANES*SCALED_W-1:0] scaled_sum_wire,
  output logic [MAX_W-1:0]          vec_max_wire,
  output logic [MAX_W-1:0]          reciprocal_wire,
  output logic [LANES*Q_W+7:0]      quantized_data_wire,
  output logic [LANES*Q_W-1:0]      output_data,
  output logic                      done_wire
);

  localparam logic signed [PROD_W-1:0] SAT_HI =
    {{(PROD_W-SCALED_W+1){1'b0}}, {(SCALED_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO =
    {{(PROD_W-SCALED_W+1){1'b1}}, {(SCALED_W-1){1'b0}}};

  state_t                    r_state;
  logic [LANES*PSUM_W-1:0]   r_psum;
  logic [7:0]                r_scale;
  logic [7:0]                r_bias;

  logic                      w_sign;
  logic                      w_nan;
  logic [E4M3_EXP_W-1:0]     w_exp;
  logic [E4M3_EXP_W-1:0]     w_eff_e;
  logic [E4M3_MAN_W-1:0]     w_man;
  logic [E4M3_MAN_W:0]       w_mant;
  logic signed [PROD_W-1:0]  w_bias_q;

  logic [LANES*SCALED_W-1:0] w_scaled_flat;
  logic [LANES*Q_W-1:0]      w_q_flat;
  logic [MAX_W-1:0]          w_mag [LANES];
  logic [MAX_W-1:0]          w_vec_max;
  logic                      w_div_start;
  logic                      w_div_busy;
  logic                      w_div_done;

  assign w_sign   = r_scale[7];
  assign w_exp    = r_scale[6:3];
  assign w_man    = r_scale[2:0];
  assign w_nan    = (w_exp == 4'hF) && (w_man == 3'h7);
  assign w_mant   = w_nan ? 4'd0 : {(w_exp != 4'd0), w_man};
  // subnormals share the exponent of e=1 with the hidden bit cleared
  assign w_eff_e  = (w_exp == 4'd0) ? 4'd1 : w_exp;
  assign w_bias_q = {{(PROD_W-8){r_bias[7]}}, r_bias} <<< FRAC_W;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PROD_W-1:0] w_ps;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_sprod;
    logic signed [PROD_W-1:0] w_shift;
    logic signed [PROD_W-1:0] w_sum;
    logic [INT_W-1:0]         w_int;
    logic [INT_W-1:0]         w_abs;
    logic                     w_neg;
    logic [QP_W-1:0]          w_pq;
    logic [QP_W-1:0]          w_qs;
    logic [6:0]               w_qm;

    assign w_ps    = {{(PROD_W-PSUM_W){r_psum[i*PSUM_W+PSUM_W-1]}}, r_psum[i*PSUM_W +: PSUM_W]};
    assign w_prod  = w_ps * $signed({{(PROD_W-E4M3_MAN_W-1){1'b0}}, w_mant});
    assign w_sprod = w_sign ? -w_prod : w_prod;
    assign w_shift = (w_sprod <<< w_eff_e) >>> SHIFT_ADJ;
    assign w_sum   = w_shift + w_bias_q;
    assign w_scaled_flat[i*SCALED_W +: SCALED_W] =
      (w_sum > SAT_HI) ? SAT_HI[SCALED_W-1:0] :
      (w_sum < SAT_LO) ? SAT_LO[SCALED_W-1:0] : w_sum[SCALED_W-1:0];

    assign w_int    = scaled_sum_wire[i*SCALED_W+FRAC_W +: INT_W];
    assign w_neg    = w_int[INT_W-1];
    assign w_abs    = w_neg ? (INT_W'(0) - w_int) : w_int;
    assign w_mag[i] = (|w_abs[INT_W-1:MAX_W]) ? {MAX_W{1'b1}} : w_abs[MAX_W-1:0];

    assign w_pq = QP_W'(w_abs) * QP_W'(reciprocal_wire) + QP_W'(ROUND_HALF);
    assign w_qs = w_pq >> RECIP_FRAC;
    assign w_qm = (w_qs > QP_W'(QMAX)) ? 7'(QMAX) : w_qs[6:0];
    assign w_q_flat[i*Q_W +: Q_W] = w_neg ? (8'd0 - {1'b0, w_qm}) : {1'b0, w_qm};
  end

  always_comb begin
    w_vec_max = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_mag[i] > w_vec_max) w_vec_max = w_mag[i];
    end
  end

  assign w_div_start = (r_state == S_MAX);
  assign output_data = quantized_data_wire[LANES*Q_W-1:0];

  ppu_recip_div u_recip_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_div_start),
    .i_divisor (w_vec_max),
    .o_busy    (w_div_busy),
    .o_done    (w_div_done),
    .o_quot    (reciprocal_wire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_IDLE;
      r_psum              <= '0;
      r_scale             <= '0;
      r_bias              <= '0;
      scaled_sum_wire     <= '0;
      vec_max_wire        <= '0;
      quantized_data_wire <= '0;
      done_wire           <= 1'b0;
    end else begin
      done_wire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_psum  <= partial_sum;
            r_scale <= scale;
            r_bias  <= bias;
            r_state <= S_SCALE;
          end
        end
        S_SCALE: begin
          scaled_sum_wire <= w_scaled_flat;
          r_state         <= S_MAX;
        end
        S_MAX: begin
          vec_max_wire <= w_vec_max;
          r_state      <= S_RECIP;
        end
        S_RECIP: begin
          if (w_div_done)       r_state <= S_QUANT;
          else if (!w_div_busy) r_state <= S_IDLE;
        end
        S_QUANT: begin
          quantized_data_wire <= {lead_one(vec_max_wire), w_q_flat};
          done_wire           <= 1'b1;
          r_state             <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu.sv
`default_nettype none
// =============================================================================
// tb_ppu : directed self-checking bench for ppu
// Revision : 1.0
// =============================================================================
module tb_ppu;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [383:0] partial_sum;
  logic [7:0]   scale;
  logic [7:0]   bias;
  logic         valid;
  logic [639:0] scaled_sum_wire;
  logic [17:0]  vec_max_wire;
  logic [17:0]  reciprocal_wire;
  logic [135:0] quantized_data_wire;
  logic [127:0] output_data;
  logic         done_wire;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ppu dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .partial_sum         (partial_sum),
    .scale               (scale),
    .bias                (bias),
    .valid               (valid),
    .scaled_sum_wire     (scaled_sum_wire),
    .vec_max_wire        (vec_max_wire),
    .reciprocal_wire     (reciprocal_wire),
    .quantized_data_wire (quantized_data_wire),
    .output_data         (output_data),
    .done_wire           (done_wire)
  );

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] fill_psum(input logic [23:0] v);
    logic [383:0] r;
    for (int i = 0; i < 16; i++) r[i*24 +: 24] = v;
    return r;
  endfunction

  function automatic logic [639:0] fill40(input logic [39:0] v);
    logic [639:0] r;
    for (int i = 0; i < 16; i++) r[i*40 +: 40] = v;
    return r;
  endfunction

  function automatic logic [127:0] fill8(input logic [7:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Returns edges from capture to done (-1 when done never arrives).
  task automatic run_op(input logic [383:0] ps, input logic [7:0] sc, input logic [7:0] bi,
                        input int hold, output int lat);
    @(negedge clk);
    partial_sum = ps;
    scale       = sc;
    bias        = bi;
    valid       = 1'b1;
    lat         = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c >= hold) valid = 1'b0;
      if (done_wire) lat = c - 1;
    end
    valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [639:0] e_scaled,
                              input logic [17:0] e_max, input logic [17:0] e_r,
                              input logic [127:0] e_q, input logic [7:0] e_exp);
    check({tag, "_scaled"}, scaled_sum_wire, e_scaled);
    check({tag, "_vecmax"}, vec_max_wire, e_max);
    check({tag, "_recip"}, reciprocal_wire, e_r);
    check({tag, "_quant"}, quantized_data_wire, {e_exp, e_q});
    check({tag, "_outdata"}, output_data, e_q);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_scaled"}, scaled_sum_wire, '0);
    check({tag, "_vecmax"}, vec_max_wire, '0);
    check({tag, "_recip"}, reciprocal_wire, '0);
    check({tag, "_quant"}, quantized_data_wire, '0);
    check({tag, "_outdata"}, output_data, '0);
    check({tag, "_done"}, done_wire, 1'b0);
  endtask

  logic [383:0] ps1, ps3;
  logic [639:0] sc1, sc3, sc4;
  logic [127:0] q3;
  int           lat;
  int           n_done;
  int           pos [3];

  initial begin
    rst_n       = 1'b0;
    valid       = 1'b0;
    partial_sum = '0;
    scale       = '0;
    bias        = '0;

    ps1 = fill_psum(24'd961517);
    sc1 = fill40(40'd24999698);
    ps3 = fill_psum(24'd500);
    ps3[23:0] = -24'sd1000;
    sc3 = fill40(40'd128000);
    sc3[39:0] = -40'sd256000;
    q3 = fill8(8'h3F);
    q3[7:0] = 8'h81;
    sc4 = fill40(-40'sd768);

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1) gamma 1.625*2^-4 with bias 1, valid held for several cycles
    run_op(ps1, 8'h1D, 8'h01, 5, lat);
    check("c1_latency", lat, 21);
    check_result("c1", sc1, 18'd97655, 18'd170, fill8(8'h7F), 8'h10);
    @(posedge clk); #1;
    check("c1_done_one_cycle", done_wire, 1'b0);

    // 2) all-zero vector: reciprocal saturates, everything else zero
    run_op(fill_psum(24'd0), 8'h38, 8'h00, 1, lat);
    check("c2_latency", lat, 21);
    check_result("c2", fill40(40'd0), 18'd0, 18'h3FFFF, fill8(8'h00), 8'h00);

    // 3) one negative dominant lane
    run_op(ps3, 8'h38, 8'h00, 1, lat);
    check("c3_latency", lat, 21);
    check_result("c3", sc3, 18'd1000, 18'd16646, q3, 8'd9);

    // 4) NaN gamma leaves only bias -3; R saturates so (3*0x3FFFF+2^16)>>17 = 6
    run_op(ps1, 8'h7F, 8'hFD, 1, lat);
    check("c4_latency", lat, 21);
    check_result("c4", sc4, 18'd3, 18'h3FFFF, fill8(8'hFA), 8'd1);

    // 5) reset during the divider phase aborts the operation
    @(negedge clk);
    partial_sum = ps1;
    scale       = 8'h1D;
    bias        = 8'h01;
    valid       = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("c5_abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done_wire) n_done++;
    end
    check("c5_no_done", n_done, 0);
    run_op(ps1, 8'h1D, 8'h01, 1, lat);
    check("c5_latency", lat, 21);
    check_result("c5", sc1, 18'd97655, 18'd170, fill8(8'h7F), 8'h10);

    // 6) valid held high: back-to-back operations every 22 cycles
    @(negedge clk);
    partial_sum = ps3;
    scale       = 8'h38;
    bias        = 8'h00;
    valid       = 1'b1;
    n_done      = 0;
    for (int c = 1; c <= 66; c++) begin
      @(posedge clk); #1;
      if (done_wire) begin
        if (n_done < 3) pos[n_done] = c;
        n_done++;
      end
    end
    valid = 1'b0;
    check("c6_pulses", n_done, 3);
    check("c6_pulse0", pos[0], 22);
    check("c6_pulse1", pos[1], 44);
    check("c6_pulse2", pos[2], 66);
    check_result("c6", sc3, 18'd1000, 18'd16646, q3, 8'd9);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done_wire) n_done++;
    end
    check("c6_idle_after", n_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
